// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack port between the MEM-stage load/store engine and the data memory.
// The request side holds every field stable from req rise until the one-cycle ack.
interface mem_access_unit_if;
  logic [31:0] addr;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output addr, req, we, be, wdata, input rdata, ack);
  modport slave  (input addr, req, we, be, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: big-endian lane steering, load extension, >=2 cycles per access.
// Stalls EX/MEM while a request is outstanding; gives up with bus_err after TIMEOUT cycles.
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  input  logic                   memRd_i,
  input  logic                   memWr_i,
  input  logic [1:0]             dSize_i,
  input  logic                   ldSigned_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            wrData_i,
  mem_access_unit_if.master      dmem,
  output logic [31:0]            ldData_q,
  output logic                   ldValid_q,
  output logic                   stall,
  output logic                   misalign,
  output logic                   bus_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [29:0]       addr_r;
  logic              we_r;
  logic [3:0]        be_r;
  logic [31:0]       wdata_r;
  logic [1:0]        size_r;
  logic [1:0]        off_r;
  logic              signed_r;
  logic [CNT_W-1:0]  cnt;

  logic              access;
  logic              aligned;
  logic              start;
  logic              timeout_hit;
  logic [3:0]        be_nxt;
  logic [31:0]       wdata_nxt;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_ext;

  assign access      = valid_i & (memRd_i | memWr_i);
  assign aligned     = (dSize_i == 2'b00) ? 1'b1 :
                       (dSize_i == 2'b01) ? ~addr_i[0] : (addr_i[1:0] == 2'b00);
  assign start       = (state == IDLE) & access & aligned;
  assign timeout_hit = (state == BUSY) & ~dmem.ack & (cnt == CNT_W'(TIMEOUT - 1));

  assign dmem.addr  = {addr_r, 2'b00};
  assign dmem.req   = (state == BUSY);
  assign dmem.we    = we_r;
  assign dmem.be    = be_r;
  assign dmem.wdata = wdata_r;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = BUSY;
          stall     = 1'b1;
        end
      end
      BUSY: begin
        if (dmem.ack || timeout_hit) state_nxt = IDLE;
        else                         stall     = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Big-endian steering: offset 0 lands in bits 31:24.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = wrData_i;
    case (dSize_i)
      2'b00: begin
        be_nxt    = 4'b1000 >> addr_i[1:0];
        wdata_nxt = {4{wrData_i[7:0]}};
      end
      2'b01: begin
        be_nxt    = addr_i[1] ? 4'b0011 : 4'b1100;
        wdata_nxt = {2{wrData_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = dmem.rdata[31:24];
    case (off_r)
      2'd1:    ld_byte = dmem.rdata[23:16];
      2'd2:    ld_byte = dmem.rdata[15:8];
      2'd3:    ld_byte = dmem.rdata[7:0];
      default: ;
    endcase
    ld_half = off_r[1] ? dmem.rdata[15:0] : dmem.rdata[31:16];
    case (size_r)
      2'b00:   ld_ext = {{24{signed_r & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{signed_r & ld_half[15]}}, ld_half};
      default: ld_ext = dmem.rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r    <= '0;
      we_r      <= 1'b0;
      be_r      <= '0;
      wdata_r   <= '0;
      size_r    <= '0;
      off_r     <= '0;
      signed_r  <= 1'b0;
      cnt       <= '0;
      ldData_q  <= '0;
      ldValid_q <= 1'b0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      ldValid_q <= 1'b0;
      misalign  <= (state == IDLE) & access & ~aligned;
      bus_err   <= timeout_hit;
      if (start) begin
        addr_r   <= addr_i[31:2];
        we_r     <= memWr_i;
        be_r     <= be_nxt;
        wdata_r  <= wdata_nxt;
        size_r   <= dSize_i;
        off_r    <= addr_i[1:0];
        signed_r <= ldSigned_i;
        cnt      <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
        if (dmem.ack && !we_r) begin
          ldData_q  <= ld_ext;
          ldValid_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: hand-computed vectors checked with immediate assertions.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, memRd_i, memWr_i, ldSigned_i;
  logic [1:0]  dSize_i;
  logic [31:0] addr_i, wrData_i;
  logic [31:0] ldData_q;
  logic        ldValid_q, stall, misalign, bus_err;
  int          checks = 0;
  int          errors = 0;

  mem_access_unit_if dmem ();

  mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .memRd_i    (memRd_i),
    .memWr_i    (memWr_i),
    .dSize_i    (dSize_i),
    .ldSigned_i (ldSigned_i),
    .addr_i     (addr_i),
    .wrData_i   (wrData_i),
    .dmem       (dmem.master),
    .ldData_q   (ldData_q),
    .ldValid_q  (ldValid_q),
    .stall      (stall),
    .misalign   (misalign),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sgn, input logic [31:0] a, input logic [31:0] wd);
    valid_i = 1'b1; memRd_i = rd; memWr_i = wr; dSize_i = sz;
    ldSigned_i = sgn; addr_i = a; wrData_i = wd;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; memRd_i = 1'b0; memWr_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle_inputs(); dSize_i = 2'b00; ldSigned_i = 1'b0;
    addr_i = '0; wrData_i = '0; dmem.ack = 1'b0; dmem.rdata = '0;
    tick(); tick();
    check("rst_req", {31'd0, dmem.req}, 32'd0);
    check("rst_we", {31'd0, dmem.we}, 32'd0);
    check("rst_be", {28'd0, dmem.be}, 32'd0);
    check("rst_addr", dmem.addr, 32'd0);
    check("rst_wdata", dmem.wdata, 32'd0);
    check("rst_ldData", ldData_q, 32'd0);
    check("rst_pulses", {29'd0, ldValid_q, misalign, bus_err}, 32'd0);
    rst = 1'b0;
    tick();

    // word load, ack on 3rd BUSY cycle
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    #1 check("wl_stall_idle", {31'd0, stall}, 32'd1);
    tick();
    check("wl_req", {31'd0, dmem.req}, 32'd1);
    check("wl_be", {28'd0, dmem.be}, 32'hF);
    check("wl_addr", dmem.addr, 32'h100);
    check("wl_we", {31'd0, dmem.we}, 32'd0);
    check("wl_stall_b1", {31'd0, stall}, 32'd1);
    tick();
    check("wl_stall_b2", {31'd0, stall}, 32'd1);
    tick();
    dmem.ack = 1'b1; dmem.rdata = 32'hDEADBEEF;
    #1 check("wl_stall_ack", {31'd0, stall}, 32'd0);
    tick();
    dmem.ack = 1'b0; idle_inputs();
    check("wl_ldValid", {31'd0, ldValid_q}, 32'd1);
    check("wl_ldData", ldData_q, 32'hDEADBEEF);
    check("wl_req_drop", {31'd0, dmem.req}, 32'd0);
    tick();
    check("wl_ldValid_off", {31'd0, ldValid_q}, 32'd0);

    // signed byte load at offset 3
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h203, 32'h0);
    tick();
    check("sb_be", {28'd0, dmem.be}, 32'h1);
    check("sb_addr", dmem.addr, 32'h200);
    dmem.ack = 1'b1; dmem.rdata = 32'h123456F0;
    tick();
    dmem.ack = 1'b0; idle_inputs();
    check("sb_ldData", ldData_q, 32'hFFFFFFF0);
    tick();

    // unsigned byte load; flipping ldSigned_i mid-access must not matter
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h203, 32'h0);
    tick();
    ldSigned_i = 1'b1;
    dmem.ack = 1'b1; dmem.rdata = 32'h123456F0;
    tick();
    dmem.ack = 1'b0; idle_inputs();
    check("ub_ldData", ldData_q, 32'h000000F0);
    check("ub_ldValid", {31'd0, ldValid_q}, 32'd1);
    tick();

    // signed half load at offset 2
    issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h702, 32'h0);
    tick();
    check("sh_be", {28'd0, dmem.be}, 32'h3);
    dmem.ack = 1'b1; dmem.rdata = 32'h12348001;
    tick();
    dmem.ack = 1'b0; idle_inputs();
    check("sh_ldData", ldData_q, 32'hFFFF8001);
    tick();

    // half store at offset 2
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h302, 32'h0000ABCD);
    tick();
    check("hs_we", {31'd0, dmem.we}, 32'd1);
    check("hs_be", {28'd0, dmem.be}, 32'h3);
    check("hs_wdata", dmem.wdata, 32'hABCDABCD);
    check("hs_addr", dmem.addr, 32'h300);
    dmem.ack = 1'b1;
    tick();
    dmem.ack = 1'b0; idle_inputs();
    check("hs_no_ldValid", {31'd0, ldValid_q}, 32'd0);
    check("hs_ldData_kept", ldData_q, 32'hFFFF8001);
    tick();

    // misaligned word load
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
    #1 check("ma_stall", {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();
    check("ma_pulse", {31'd0, misalign}, 32'd1);
    check("ma_no_req", {31'd0, dmem.req}, 32'd0);
    tick();
    check("ma_pulse_off", {31'd0, misalign}, 32'd0);

    // timeout: no ack for 16 BUSY cycles
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    tick();
    for (int i = 0; i < 15; i++) begin
      check($sformatf("to_stall_%0d", i), {30'd0, stall, dmem.req}, 32'd3);
      tick();
    end
    check("to_stall_release", {31'd0, stall}, 32'd0);
    check("to_no_err_yet", {31'd0, bus_err}, 32'd0);
    tick();
    idle_inputs();
    check("to_bus_err", {31'd0, bus_err}, 32'd1);
    check("to_req_drop", {31'd0, dmem.req}, 32'd0);
    check("to_ldData_kept", ldData_q, 32'hFFFF8001);
    check("to_no_ldValid", {31'd0, ldValid_q}, 32'd0);
    tick();
    check("to_bus_err_off", {31'd0, bus_err}, 32'd0);

    // reset in 2nd BUSY cycle, late ack ignored
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; idle_inputs();
    dmem.ack = 1'b1; dmem.rdata = 32'hCAFEF00D;
    #1 check("rb_req", {30'd0, dmem.req, stall}, 32'd0);
    tick();
    dmem.ack = 1'b0;
    check("rb_no_ldValid", {31'd0, ldValid_q}, 32'd0);
    check("rb_ldData", ldData_q, 32'd0);
    tick();

    // read and write both set: store wins
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h600, 32'h11223344);
    tick();
    check("rw_we", {31'd0, dmem.we}, 32'd1);
    check("rw_be", {28'd0, dmem.be}, 32'hF);
    check("rw_wdata", dmem.wdata, 32'h11223344);
    dmem.ack = 1'b1; dmem.rdata = 32'h55555555;
    tick();
    dmem.ack = 1'b0; idle_inputs();
    check("rw_no_ldValid", {31'd0, ldValid_q}, 32'd0);
    check("rw_req_drop", {31'd0, dmem.req}, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine, directly downstream of the EX/MEM pipeline register; consumes its address, store data and memory controls.
- Drives a req/ack data-memory port.
- Performs big-endian byte/half/word lane steering and load sign/zero extension.
- Raises a stall to the hazard unit while an access is outstanding, so EX/MEM holds.

Parameters:
- TIMEOUT, 16: max cycles in BUSY without dmem_ack before the access is abandoned with bus_err.
- CNT_W, 5: width of the wait counter; must hold TIMEOUT.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- valid_i  input  1  EX/MEM slot holds a real instruction
- memRd_i  input  1  load
- memWr_i  input  1  store
- dSize_i  input  2  00 byte, 01 half, 10 word, 11 treated as word
- ldSigned_i  input  1  1 = sign-extend sub-word load, 0 = zero-extend
- addr_i  input  32  effective address (EX ALU result)
- wrData_i  input  32  store data, right-justified
- dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- dmem_req  output  1  request, held until ack
- dmem_we  output  1  1 = write
- dmem_be  output  4  byte enables, bit3 = bits 31:24
- dmem_wdata  output  32  lane-replicated store data
- dmem_rdata  input  32  read data, valid with dmem_ack
- dmem_ack  input  1  one-cycle completion strobe
- ldData_q  output  32  aligned, extended load result
- ldValid_q  output  1  one-cycle pulse: ldData_q newly updated
- stall  output  1  combinational hold request to hazard unit
- misalign  output  1  one-cycle pulse: misaligned access rejected
- bus_err  output  1  one-cycle pulse: access timed out

Behaviour:
- Reset (rst=1 at edge): state IDLE; dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, ldData_q=0, ldValid_q=0, misalign=0, bus_err=0, counter=0. Reset mid-BUSY abandons the access; a later ack arriving in IDLE is ignored.
- access = valid_i & (memRd_i | memWr_i).
- Store wins when memRd_i and memWr_i are both set; no ldValid_q for that access.
- Alignment:
  - half requires addr[0]=0; word requires addr[1:0]=00.
  - Misaligned access in IDLE: no request, misalign pulses next cycle, stall=0.
- States:
  - IDLE: an aligned access latches addr/we/be/wdata/size/offset/signed into registers and moves to BUSY; dmem_req=1 from the next cycle.
  - BUSY: dmem_req and all dmem_* outputs held stable; counter increments each cycle.
    - dmem_ack: go to IDLE. For a load, ldData_q <= extracted dmem_rdata and ldValid_q pulses.
    - Counter reaches TIMEOUT-1 without ack: go to IDLE, bus_err pulses, ldData_q unchanged.
- stall = (IDLE & access & aligned) | (BUSY & ~dmem_ack & ~timeout_hit). Stall drops in the ack cycle, so EX/MEM advances on that same edge.
- Minimum latency: 2 cycles per access (1 stall cycle plus the ack cycle).
- Store lanes (big-endian, offset = addr[1:0]):
  - byte: wdata = {4{wr[7:0]}}, be = 1000 >> offset.
  - half: wdata = {2{wr[15:0]}}, be = 1100 (offset 0) or 0011 (offset 2).
  - word: be = 1111.
- Load extraction:
  - byte lane bits [31-8*off -: 8]; half lane [31:16] or [15:0].
  - Extend to 32 bits per the latched ldSigned; word passes through.
- ldValid_q, misalign and bus_err are single-cycle pulses and never overlap.

Test Plan:
- Word load, addr=0x100, ack on 3rd BUSY cycle with rdata=0xDEADBEEF -> stall high 3 cycles; ldData_q=0xDEADBEEF, ldValid_q pulse; dmem_be=1111.
- Signed byte load, addr=0x203, rdata=0x123456F0 -> ldData_q=0xFFFFFFF0. Same access unsigned -> 0x000000F0.
- Half store, addr=0x302, wrData=0x0000ABCD -> dmem_we=1, be=0011, wdata=0xABCDABCD, dmem_addr=0x300.
- Word load at addr=0x101 -> no dmem_req, misalign pulse, stall never asserted.
- Load, no ack for TIMEOUT=16 cycles -> bus_err pulse, req drops, stall releases, ldData_q keeps prior value.
- Edge cases:
  - rst asserted in the 2nd BUSY cycle, then ack arrives -> req=0, no ldValid_q.
  - memRd_i=memWr_i=1 -> write issued, no ldValid_q.
